// File: rtl/mining_pkg.sv
// Shared definitions for the mining datapath.
//
// Contents:
//   WORK_W / TARGET_W / NONCE_W : widths of the work block, target and nonce
//   dispatch_state_t            : work_dispatcher FSM encoding
//   base_nonce()                : first nonce of core idx when the 32-bit
//                                 nonce space is split into 2**log2n slices
package mining_pkg;

  localparam int WORK_W   = 640;
  localparam int TARGET_W = 32;
  localparam int NONCE_W  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    ABORT = 2'd3
  } dispatch_state_t;

  // The shift is done at 64 bits so that a single core (log2n = 0) ends up
  // with a base of 0 rather than relying on a full-width 32-bit shift.
  function automatic logic [NONCE_W-1:0] base_nonce(input int idx, input int log2n);
    logic [63:0] wide;
    wide = 64'(idx) << (NONCE_W - log2n);
    return wide[NONCE_W-1:0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//
// Picks the first asserted request at or above ptr, wrapping around.
// The pointer register lives in the caller; this block only searches.
//
// Ports:
//   req         in  N      request vector
//   ptr         in  PTR_W  index at which the search starts
//   en          in  1      search enable; no grant when low
//   grant_valid out 1      a request was granted
//   grant_idx   out PTR_W  index of the granted request (0 when none)
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             en,
  output logic             grant_valid,
  output logic [PTR_W-1:0] grant_idx
);

  int idx;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    if (en) begin
      for (int k = 0; k < N; k++) begin
        idx = (int'(ptr) + k) % N;
        if (!grant_valid && req[idx]) begin
          grant_valid = 1'b1;
          grant_idx   = PTR_W'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/work_dispatcher.sv
// Work dispatcher between the UART command parser and NUM_CORES hash cores.
//
// A new work item (valid pulse) is latched into core_work/core_target and
// broadcast to all cores; each core owns a disjoint slice of the nonce space
// starting at core_base. The FSM starts the cores, and aborts then restarts
// them when superseding work arrives during RUN. Results from the cores are
// held one per core and reported round-robin to the parser.
//
// Report handshake: a result is offered only when host_ready is high and the
// found register is low. The parser takes every found pulse as accepted (no
// per-transfer ready); host_ready is a level meaning "transmitter idle", so a
// report is never issued while it is low, and found is always followed by at
// least one idle cycle before the next report.
//
// Optional build: define WORK_DISPATCHER_STATS_EN to add saturating
// found_count / drop_count outputs.
//
// Ports:
//   clock, reset     clock; asynchronous active-high reset
//   valid            one-cycle new-work pulse; work/target sampled with it
//   work, target     new work block and hash target
//   host_ready       parser transmitter idle (level)
//   found, nonce     one-cycle result pulse and held result nonce
//   core_start       one-cycle broadcast start
//   core_abort       one-cycle broadcast abort
//   core_work        registered work to all cores
//   core_target      registered target to all cores
//   core_base        per-core start nonce, slice i = [32i+31:32i]
//   core_found       per-core one-cycle found pulse
//   core_nonce       per-core nonce, valid with core_found
//   core_done        per-core one-cycle range-exhausted pulse
//   busy             FSM not IDLE
//   exhausted        one-cycle pulse: all cores done, all results reported
//   found_count      (stats build) reports issued, saturating
//   drop_count       (stats build) results discarded, saturating
module work_dispatcher
  import mining_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int LOG2_CORES = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         valid,
  input  logic [WORK_W-1:0]            work,
  input  logic [TARGET_W-1:0]          target,
  input  logic                         host_ready,
  output logic                         found,
  output logic [NONCE_W-1:0]           nonce,
  output logic                         core_start,
  output logic                         core_abort,
  output logic [WORK_W-1:0]            core_work,
  output logic [TARGET_W-1:0]          core_target,
  output logic [NUM_CORES*NONCE_W-1:0] core_base,
  input  logic [NUM_CORES-1:0]         core_found,
  input  logic [NUM_CORES*NONCE_W-1:0] core_nonce,
  input  logic [NUM_CORES-1:0]         core_done,
  output logic                         busy,
  output logic                         exhausted
`ifdef WORK_DISPATCHER_STATS_EN
  ,
  output logic [15:0]                  found_count,
  output logic [15:0]                  drop_count
`endif
);

  localparam int PTR_W = (LOG2_CORES > 0) ? LOG2_CORES : 1;

  dispatch_state_t state, state_next;
  logic start_next, abort_next, exhaust_next;

  logic [NUM_CORES-1:0] pending;
  logic [NUM_CORES-1:0] done_mask;
  logic [NUM_CORES-1:0] capture_mask;
  logic [NUM_CORES-1:0] grant_onehot;
  logic [NONCE_W-1:0]   captured [NUM_CORES];
  logic [NONCE_W-1:0]   grant_nonce;

  logic [PTR_W-1:0] rr_ptr, ptr_next;
  logic             grant_en, grant_valid;
  logic [PTR_W-1:0] grant_idx;

  // ---------------------------------------------------------------------
  // Static nonce partition
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_base
    assign core_base[gi*NONCE_W +: NONCE_W] = base_nonce(gi, LOG2_CORES);
  end

  assign busy = (state != IDLE);

  // ---------------------------------------------------------------------
  // Work/target latch: sampled on every valid regardless of state, so the
  // start pulse (at least one cycle later) always sees the newest work.
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      core_work   <= '0;
      core_target <= '0;
    end else if (valid) begin
      core_work   <= work;
      core_target <= target;
    end
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_next   = state;
    start_next   = 1'b0;
    abort_next   = 1'b0;
    exhaust_next = 1'b0;
    unique case (state)
      IDLE: begin
        if (valid) state_next = START;
      end
      START: begin
        start_next = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        if (valid) begin
          state_next = ABORT;
        end else if ((&done_mask) && (pending == '0) && (core_found == '0)) begin
          // A result arriving in the very cycle we would finish keeps us
          // in RUN so it is captured and reported rather than lost.
          state_next   = IDLE;
          exhaust_next = 1'b1;
        end
      end
      ABORT: begin
        abort_next = 1'b1;
        state_next = START;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      core_start <= 1'b0;
      core_abort <= 1'b0;
      exhausted  <= 1'b0;
    end else begin
      state      <= state_next;
      core_start <= start_next;
      core_abort <= abort_next;
      exhausted  <= exhaust_next;
    end
  end

  // ---------------------------------------------------------------------
  // Result capture. Only RUN accepts core results; an occupied slot keeps
  // its older nonce and the newcomer is discarded.
  // ---------------------------------------------------------------------
  assign capture_mask = (state == RUN) ? (core_found & ~pending) : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending   <= '0;
      done_mask <= '0;
      for (int i = 0; i < NUM_CORES; i++) captured[i] <= '0;
    end else begin
      // Grant only clears set bits and capture only sets clear bits, so
      // the two never touch the same core in one cycle.
      if (state == ABORT) pending <= '0;
      else                pending <= (pending & ~grant_onehot) | capture_mask;

      done_mask <= (state == RUN) ? (done_mask | core_done) : '0;

      for (int i = 0; i < NUM_CORES; i++) begin
        if (capture_mask[i]) captured[i] <= core_nonce[i*NONCE_W +: NONCE_W];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Report arbitration. Requiring found==0 gives the two-cycle spacing.
  // ---------------------------------------------------------------------
  assign grant_en = (|pending) && host_ready && !found && (state != ABORT);

  rr_arbiter #(
    .N     (NUM_CORES),
    .PTR_W (PTR_W)
  ) u_arb (
    .req         (pending),
    .ptr         (rr_ptr),
    .en          (grant_en),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    grant_nonce  = '0;
    grant_onehot = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (grant_valid && (int'(grant_idx) == i)) begin
        grant_nonce     = captured[i];
        grant_onehot[i] = 1'b1;
      end
    end
    ptr_next = (int'(grant_idx) == NUM_CORES - 1) ? '0 : grant_idx + PTR_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      found  <= 1'b0;
      nonce  <= '0;
      rr_ptr <= '0;
    end else begin
      found <= grant_valid;
      if (grant_valid) begin
        nonce  <= grant_nonce;
        rr_ptr <= ptr_next;
      end
    end
  end

`ifdef WORK_DISPATCHER_STATS_EN
  // ---------------------------------------------------------------------
  // Statistics. Drops are results lost to an occupied slot in RUN, plus
  // everything flushed or arriving while the abort is taking effect.
  // ---------------------------------------------------------------------
  logic [NUM_CORES-1:0] drop_mask;
  logic [4:0]           drop_num;
  logic [16:0]          drop_sum;
  logic [16:0]          found_sum;

  always_comb begin
    drop_mask = '0;
    if (state == RUN)        drop_mask = core_found & pending;
    else if (state == ABORT) drop_mask = core_found | pending;
    drop_num = '0;
    for (int i = 0; i < NUM_CORES; i++) drop_num = drop_num + 5'(drop_mask[i]);
    drop_sum  = {1'b0, drop_count} + 17'(drop_num);
    found_sum = {1'b0, found_count} + 17'(grant_valid);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      found_count <= '0;
      drop_count  <= '0;
    end else begin
      found_count <= found_sum[16] ? 16'hFFFF : found_sum[15:0];
      drop_count  <= drop_sum[16]  ? 16'hFFFF : drop_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_work_dispatcher.sv
// Directed testbench for work_dispatcher (NUM_CORES = 4).
module tb_work_dispatcher;
  import mining_pkg::*;

  localparam int NUM_CORES  = 4;
  localparam int LOG2_CORES = 2;

  logic                         clock = 1'b0;
  logic                         reset;
  logic                         valid;
  logic [WORK_W-1:0]            work;
  logic [TARGET_W-1:0]          target;
  logic                         host_ready;
  logic                         found;
  logic [NONCE_W-1:0]           nonce;
  logic                         core_start;
  logic                         core_abort;
  logic [WORK_W-1:0]            core_work;
  logic [TARGET_W-1:0]          core_target;
  logic [NUM_CORES*NONCE_W-1:0] core_base;
  logic [NUM_CORES-1:0]         core_found;
  logic [NUM_CORES*NONCE_W-1:0] core_nonce;
  logic [NUM_CORES-1:0]         core_done;
  logic                         busy;
  logic                         exhausted;
`ifdef WORK_DISPATCHER_STATS_EN
  logic [15:0]                  found_count;
  logic [15:0]                  drop_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [NONCE_W-1:0] exp_q[$];
  logic [WORK_W-1:0]  pat1, pat2;

  work_dispatcher #(
    .NUM_CORES  (NUM_CORES),
    .LOG2_CORES (LOG2_CORES)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .valid       (valid),
    .work        (work),
    .target      (target),
    .host_ready  (host_ready),
    .found       (found),
    .nonce       (nonce),
    .core_start  (core_start),
    .core_abort  (core_abort),
    .core_work   (core_work),
    .core_target (core_target),
    .core_base   (core_base),
    .core_found  (core_found),
    .core_nonce  (core_nonce),
    .core_done   (core_done),
    .busy        (busy),
    .exhausted   (exhausted)
`ifdef WORK_DISPATCHER_STATS_EN
    ,
    .found_count (found_count),
    .drop_count  (drop_count)
`endif
  );

  // Clock
  always #5 clock = ~clock;

  // Drivers
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic dispatch(input logic [WORK_W-1:0] w, input logic [TARGET_W-1:0] t);
    valid  = 1'b1;
    work   = w;
    target = t;
    tick();
    valid  = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset;
    reset      = 1'b1;
    valid      = 1'b0;
    work       = '0;
    target     = '0;
    host_ready = 1'b0;
    core_found = '0;
    core_nonce = '0;
    core_done  = '0;
    tick();
    tick();
    n_checks++;
    if ({found, core_start, core_abort, busy, exhausted} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000", {found, core_start, core_abort, busy, exhausted});
    end
    n_checks++;
    if (nonce !== 32'h0 || core_target !== 32'h0 || core_work !== '0) begin
      n_fail++;
      $display("FAIL reset_data: nonce %h target %h expected 0", nonce, core_target);
    end
`ifdef WORK_DISPATCHER_STATS_EN
    n_checks++;
    if (found_count !== 16'h0 || drop_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_stats: got %h/%h expected 0/0", found_count, drop_count);
    end
`endif
    reset = 1'b0;
    tick();
  endtask

  task automatic test_dispatch;
    dispatch(pat1, 32'h0000FFFF);
    n_checks++;
    if (core_start !== 1'b0) begin
      n_fail++;
      $display("FAIL start_early: got %b expected 0", core_start);
    end
    n_checks++;
    if (core_work !== pat1 || core_target !== 32'h0000FFFF) begin
      n_fail++;
      $display("FAIL work_latch: target got %h expected 0000ffff", core_target);
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_start: got %b expected 1", busy);
    end
    tick();
    n_checks++;
    if (core_start !== 1'b1) begin
      n_fail++;
      $display("FAIL start_pulse: got %b expected 1", core_start);
    end
    tick();
    n_checks++;
    if (core_start !== 1'b0) begin
      n_fail++;
      $display("FAIL start_single: got %b expected 0", core_start);
    end
    n_checks++;
    if (core_base !== {32'hC0000000, 32'h80000000, 32'h40000000, 32'h00000000}) begin
      n_fail++;
      $display("FAIL core_base: got %h expected c0000000800000004000000000000000", core_base);
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_run: got %b expected 1", busy);
    end
  endtask

  task automatic test_round_robin;
    int last;
    logic [NONCE_W-1:0] exp;
    last = -1;
    exp_q.push_back(32'd11);
    exp_q.push_back(32'd22);
    exp_q.push_back(32'd33);
    host_ready = 1'b1;
    core_found = 4'b1110;
    core_nonce = {32'd33, 32'd22, 32'd11, 32'd0};
    tick();
    core_found = '0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (found === 1'b1) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        n_checks++;
        if (nonce !== exp) begin
          n_fail++;
          $display("FAIL rr_nonce: cycle %0d got %0d expected %0d", c, nonce, exp);
        end
        if (last >= 0) begin
          n_checks++;
          if (c - last !== 2) begin
            n_fail++;
            $display("FAIL rr_spacing: got %0d cycles expected 2", c - last);
          end
        end
        last = c;
      end
    end
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL rr_missing: %0d reports outstanding expected 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure;
    int early, pulses;
    logic [NONCE_W-1:0] seen;
`ifdef WORK_DISPATCHER_STATS_EN
    logic [15:0] drop0;
    drop0 = drop_count;
`endif
    early  = 0;
    pulses = 0;
    seen   = '0;
    host_ready = 1'b0;
    for (int c = 0; c < 50; c++) begin
      core_found = '0;
      if (c == 0) begin
        core_found = 4'b0001;
        core_nonce = {96'h0, 32'hDEADBEEF};
      end else if (c == 10) begin
        core_found = 4'b0001;
        core_nonce = {96'h0, 32'h12345678};
      end
      tick();
      if (found === 1'b1) early++;
    end
    core_found = '0;
    n_checks++;
    if (early !== 0) begin
      n_fail++;
      $display("FAIL bp_hold: got %0d pulses expected 0", early);
    end
    host_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (found === 1'b1) begin
        pulses++;
        seen = nonce;
      end
    end
    n_checks++;
    if (pulses !== 1) begin
      n_fail++;
      $display("FAIL bp_count: got %0d pulses expected 1", pulses);
    end
    n_checks++;
    if (seen !== 32'hDEADBEEF || nonce !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL bp_nonce: got %h held %h expected deadbeef", seen, nonce);
    end
`ifdef WORK_DISPATCHER_STATS_EN
    n_checks++;
    if (drop_count - drop0 !== 16'd1) begin
      n_fail++;
      $display("FAIL bp_drops: got %0d expected 1", drop_count - drop0);
    end
`endif
  endtask

  task automatic test_abort;
    int pulses;
`ifdef WORK_DISPATCHER_STATS_EN
    logic [15:0] drop0;
`endif
    pulses = 0;
    host_ready = 1'b0;
    core_found = 4'b0101;
    core_nonce = {32'h0, 32'hA2, 32'h0, 32'hA0};
    tick();
    core_found = '0;
`ifdef WORK_DISPATCHER_STATS_EN
    drop0 = drop_count;
`endif
    dispatch(pat2, 32'h000000FF);
    n_checks++;
    if (core_abort !== 1'b0 || core_work !== pat2) begin
      n_fail++;
      $display("FAIL abort_early: abort %b expected 0 with new work", core_abort);
    end
    tick();
    n_checks++;
    if (core_abort !== 1'b1 || core_start !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_pulse: abort/start got %b%b expected 10", core_abort, core_start);
    end
    tick();
    n_checks++;
    if (core_abort !== 1'b0 || core_start !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_restart: abort/start got %b%b expected 01", core_abort, core_start);
    end
    host_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (found === 1'b1 || core_abort === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL abort_flush: got %0d reports expected 0", pulses);
    end
`ifdef WORK_DISPATCHER_STATS_EN
    n_checks++;
    if (drop_count - drop0 !== 16'd2) begin
      n_fail++;
      $display("FAIL abort_drops: got %0d expected 2", drop_count - drop0);
    end
`endif
  endtask

  task automatic test_exhaustion;
    int early;
    early = 0;
    host_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      core_done  = 4'b0001 << c;
      core_found = (c == 2) ? 4'b0100 : 4'b0000;
      core_nonce = {32'h0, 32'h77, 32'h0, 32'h0};
      tick();
    end
    core_done  = '0;
    core_found = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (exhausted === 1'b1 || busy !== 1'b1) early++;
    end
    n_checks++;
    if (early !== 0) begin
      n_fail++;
      $display("FAIL exh_early: got %0d bad cycles expected 0", early);
    end
    host_ready = 1'b1;
    tick();
    n_checks++;
    if (found !== 1'b1 || nonce !== 32'h77 || exhausted !== 1'b0) begin
      n_fail++;
      $display("FAIL exh_found: found %b nonce %h exh %b expected 1 77 0", found, nonce, exhausted);
    end
    tick();
    n_checks++;
    if (exhausted !== 1'b1 || busy !== 1'b0 || found !== 1'b0) begin
      n_fail++;
      $display("FAIL exh_pulse: exh %b busy %b found %b expected 1 0 0", exhausted, busy, found);
    end
    tick();
    n_checks++;
    if (exhausted !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL exh_single: exh %b busy %b expected 0 0", exhausted, busy);
    end
`ifdef WORK_DISPATCHER_STATS_EN
    n_checks++;
    if (found_count !== 16'd5) begin
      n_fail++;
      $display("FAIL found_count: got %0d expected 5", found_count);
    end
`endif
  endtask

  task automatic test_reset_mid_run;
    int stray;
    stray = 0;
    dispatch(pat1, 32'h00001234);
    tick();
    tick();
    host_ready = 1'b0;
    core_found = 4'b0011;
    core_nonce = {64'h0, 32'h55, 32'h44};
    tick();
    core_found = '0;
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({found, core_start, core_abort, busy, exhausted} !== 5'b0) begin
      n_fail++;
      $display("FAIL rst_flags: got %b expected 00000", {found, core_start, core_abort, busy, exhausted});
    end
    n_checks++;
    if (nonce !== 32'h0 || core_target !== 32'h0 || core_work !== '0) begin
      n_fail++;
      $display("FAIL rst_data: nonce %h target %h expected 0", nonce, core_target);
    end
`ifdef WORK_DISPATCHER_STATS_EN
    n_checks++;
    if (found_count !== 16'h0 || drop_count !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_stats: got %h/%h expected 0/0", found_count, drop_count);
    end
`endif
    tick();
    reset      = 1'b0;
    host_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (found === 1'b1 || core_abort === 1'b1 || core_start === 1'b1 || busy === 1'b1) stray++;
    end
    n_checks++;
    if (stray !== 0) begin
      n_fail++;
      $display("FAIL rst_quiet: got %0d active cycles expected 0", stray);
    end
  endtask

  initial begin
    for (int i = 0; i < WORK_W / 32; i++) begin
      pat1[i*32 +: 32] = 32'h1000_0000 + i * 32'h0101_0101;
      pat2[i*32 +: 32] = 32'hF000_0000 - i * 32'h0011_0011;
    end
    test_reset();
    test_dispatch();
    test_round_robin();
    test_backpressure();
    test_abort();
    test_exhaustion();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/work_dispatcher.md
Name: work_dispatcher

Overview:
Sits between the UART command parser and an array of NUM_CORES hash cores. On each new work item it loads work and target into every core, and gives each core a disjoint nonce sub-range. It then starts the cores and aborts them when superseding work arrives. Found results come back from all cores; the block arbitrates them round-robin and forwards them one at a time to the parser's found/nonce inputs, pacing them with a host_ready handshake.

Parameters:
NUM_CORES, 4, number of hash cores; power of two, 1..16
LOG2_CORES, 2, log2(NUM_CORES); must be consistent with NUM_CORES

Ports:
clock  in  1  global clock
reset  in  1  global reset
valid  in  1  one-cycle pulse: new work from parser
work  in  640  80-byte work data, sampled when valid=1
target  in  32  hash target, sampled when valid=1
host_ready  in  1  parser transmitter idle; level signal
found  out  1  one-cycle pulse to parser: result available
nonce  out  32  reported nonce; held until next report
core_start  out  1  one-cycle broadcast start pulse
core_abort  out  1  one-cycle broadcast abort pulse
core_work  out  640  registered work to all cores
core_target  out  32  registered target to all cores
core_base  out  NUM_CORES*32  per-core start nonce; core i uses slice [32i+31:32i]
core_found  in  NUM_CORES  per-core one-cycle found pulse
core_nonce  in  NUM_CORES*32  per-core nonce, valid with core_found
core_done  in  NUM_CORES  per-core one-cycle range-exhausted pulse
busy  out  1  high when state != IDLE
exhausted  out  1  one-cycle pulse: all cores done, all results reported

Behaviour:
- Reset is asynchronous and active-high; clock is clock.
- Reset values: all outputs are 0, the FSM is in IDLE, all pending/done flags are clear, and the round-robin pointer is 0.
- Reset mid-operation discards every flag. No abort pulse is generated.
- core_work and core_target are registered on valid in any state, so they are valid one cycle after the valid pulse.
- core_base[i] = i << (32 - LOG2_CORES). This is constant; register it or tie it off.
- When NUM_CORES = 1, core_base = 0.
- FSM states: IDLE, START, RUN, ABORT.
  - IDLE --valid--> START.
  - START: core_start=1 for exactly one cycle, then go to RUN.
  - RUN --valid--> ABORT.
  - RUN --(done_mask all ones and no pending)--> IDLE, with exhausted=1 for one cycle.
  - ABORT: core_abort=1 for one cycle, clear pending and done_mask, then go to START.
  - A valid arriving while in START or ABORT is not re-queued: work is re-sampled, and cores see the new work because start follows the register update.
- Result capture (RUN only):
  - core_found[i] sets pending[i] and captures core_nonce slice i.
  - If pending[i] is already set, the new result is dropped and the older result is kept.
  - core_done[i] sets done_mask[i].
  - found and done on the same core in the same cycle are both captured.
  - core_found and core_done are ignored in IDLE, START and ABORT.
- Report grant:
  - Condition: any pending, host_ready=1, found register currently 0, and state is not ABORT.
  - The grantee is the first pending index at or above the rr pointer, wrapping around.
  - On grant: found=1 next cycle, nonce = captured value, pending[grantee] cleared, pointer = grantee+1 mod NUM_CORES.
  - Minimum spacing between found pulses is 2 cycles.
- Simultaneous grant condition and valid in RUN: the grant proceeds this cycle, then ABORT clears the rest.
- An abort issued in the same cycle as a new core_found discards that result.

Optional Feature:
Macro: WORK_DISPATCHER_STATS_EN.
- Defined: adds outputs found_count (16) and drop_count (16).
  - found_count increments on each found pulse.
  - drop_count increments on each result dropped because of an already-set pending flag or an abort.
  - Both counters saturate at 16'hFFFF and are cleared by reset only.
- Undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package mining_pkg holds:
  - WORK_W=640, TARGET_W=32, NONCE_W=32
  - dispatcher state encodings (IDLE=2'd0, START=2'd1, RUN=2'd2, ABORT=2'd3)
- Sub-module rr_arbiter (parameter N): inputs req[N], ptr, en; outputs grant_valid and grant_idx. It is combinational, and the pointer register stays in work_dispatcher.

Test Plan:
- Dispatch: reset, valid with work=pattern and target=32'h0000FFFF, NUM_CORES=4.
  - core_start pulses exactly 2 cycles after valid.
  - core_base = {32'hC0000000, 32'h80000000, 32'h40000000, 32'h0}.
  - busy=1.
- Round-robin: in RUN, core_found on cores 1, 2 and 3 in the same cycle with nonces 11, 22, 33, host_ready=1.
  - found pulses carry 11, 22, 33 in order, spaced 2 cycles apart.
- Backpressure: core 0 finds 32'hDEADBEEF with host_ready=0 for 50 cycles.
  - No found pulse during that time.
  - A second core_found on core 0 is dropped.
  - After host_ready rises, a single found carries 32'hDEADBEEF.
- Abort: valid during RUN with 2 results pending.
  - core_abort pulses once, then core_start.
  - The pending results are never reported; drop_count=2 with STATS_EN.
- Exhaustion: all 4 core_done pulses arrive across different cycles and one result is pending.
  - exhausted pulses only after that result's found, then busy=0.
- Reset: assert reset mid-RUN with results pending.
  - All outputs go to 0 immediately; no found or abort follows after release.
